// File: rtl/imm_pack_pkg.sv
// Shared control definitions for the instruction packer and the immediate extender.
// Latency: none (types and constants only).
// Backpressure: not applicable.
// Contents: ImmSrc encoding, OP_IMM opcode, request struct, immediate-range helper.
package imm_pack_pkg;

  // ImmSrc encoding shared with the extender; values 5..7 are unused/invalid.
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_B = 3'd1,
    IMM_S = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_t;

  localparam logic [6:0] OP_IMM = 7'h13;

  // Bits that must all carry the sign for each signed immediate format.
  localparam logic [31:0] SIGN_MASK_IS = 32'hFFFF_F800;  // imm[31:11]
  localparam logic [31:0] SIGN_MASK_B  = 32'hFFFF_F000;  // imm[31:12]
  localparam logic [31:0] SIGN_MASK_J  = 32'hFFF0_0000;  // imm[31:20]

  // One packing request, as presented on the input stream.
  typedef struct packed {
    logic [2:0]  imm_src;   // raw 3 bits so invalid codes can be carried
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } pack_req_t;

  // True when every bit selected by mask is identical (all 0 or all 1).
  function automatic logic uniform(input logic [31:0] v, input logic [31:0] mask);
    return ((v & mask) == 32'h0) || ((v & mask) == mask);
  endfunction

endpackage

// File: rtl/imm_pack_if.sv
// Packer stream bundle: request stream in, packed-word stream out, error counter.
// Latency: none (wires only).
// Backpressure: valid/ready on both streams.
// Modports: slave = packer side, master = producer/consumer (bench or loader) side.
interface imm_pack_if #(
  parameter int ADDR_WIDTH = 32
);
  import imm_pack_pkg::*;

  // request stream
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_imm_src;
  logic [6:0]            in_opcode;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [2:0]            in_funct3;
  logic [6:0]            in_funct7;
  logic [31:0]           in_imm;

  // packed-word stream
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_err;
  logic [15:0]           err_count;

  modport slave (
    input  in_valid, in_imm_src, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );

  modport master (
    output in_valid, in_imm_src, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );

endinterface

// File: rtl/imm_pack_scatter.sv
// imm_scatter: scatters a 32-bit immediate and register fields into an I/S/B/J/U word.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
// Ports: req (fields + ImmSrc), instr (packed word), err (only with IMM_PACK_CHECK_EN).
// IMM_PACK_CHECK_EN: when defined, err flags immediates the format cannot encode.
module imm_scatter
  import imm_pack_pkg::*;
(
  input  pack_req_t   req,
  output logic [31:0] instr
`ifdef IMM_PACK_CHECK_EN
  ,
  output logic        err
`endif
);

  // Shift-immediate form: funct7 occupies the top of the I immediate field.
  logic is_shift;
  assign is_shift = (req.imm_src == IMM_I) && (req.opcode == OP_IMM) &&
                    ((req.funct3 == 3'd1) || (req.funct3 == 3'd5));

  always_comb begin
    // I layout is the fallback for both IMM_I and the invalid codes.
    instr = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
    case (req.imm_src)
      IMM_I: begin
        if (is_shift) begin
          instr = {req.funct7, req.imm[4:0], req.rs1, req.funct3, req.rd, req.opcode};
        end
      end
      IMM_S: instr = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
      IMM_B: instr = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                      req.imm[4:1], req.imm[11], req.opcode};
      IMM_J: instr = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                      req.rd, req.opcode};
      IMM_U: instr = {req.imm[31:12], req.rd, req.opcode};
      default: ;
    endcase
  end

`ifdef IMM_PACK_CHECK_EN
  // An immediate is representable when extending the packed word gives it back.
  always_comb begin
    err = 1'b1;
    case (req.imm_src)
      IMM_I: err = is_shift ? (|req.imm[31:5]) : !uniform(req.imm, SIGN_MASK_IS);
      IMM_S: err = !uniform(req.imm, SIGN_MASK_IS);
      IMM_B: err = req.imm[0] || !uniform(req.imm, SIGN_MASK_B);
      IMM_J: err = req.imm[0] || !uniform(req.imm, SIGN_MASK_J);
      IMM_U: err = |req.imm[11:0];
      default: err = 1'b1;
    endcase
  end
`endif

endmodule

// File: rtl/imm_pack.sv
// imm_pack: packs instruction fields + immediate into a word tagged with a memory address.
// Latency: 1 cycle from input handshake to out_valid; one word per cycle sustained.
// Backpressure: in_ready = !out_valid || out_ready (0 in reset); held word stable while stalled.
// Ports: clk, rst (sync, active-high), bus (imm_pack_if.slave) carrying both streams.
// Params: ADDR_WIDTH (out_addr width), BASE_ADDR (address of first word after reset).
// IMM_PACK_CHECK_EN: when defined, out_err/err_count are live; otherwise both are tied to 0.
module imm_pack
  import imm_pack_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic        clk,
  input  logic        rst,
  imm_pack_if.slave   bus
);

  pack_req_t   req;
  logic [31:0] instr_nxt;
  logic        take;
  logic        drain;

  assign req = '{
    imm_src: bus.in_imm_src,
    opcode:  bus.in_opcode,
    rd:      bus.in_rd,
    rs1:     bus.in_rs1,
    rs2:     bus.in_rs2,
    funct3:  bus.in_funct3,
    funct7:  bus.in_funct7,
    imm:     bus.in_imm
  };

  assign bus.in_ready = !rst && (!bus.out_valid || bus.out_ready);
  assign take         = bus.in_valid && bus.in_ready;
  assign drain        = bus.out_valid && bus.out_ready;

`ifdef IMM_PACK_CHECK_EN
  logic err_nxt;

  imm_scatter u_scatter (
    .req   (req),
    .instr (instr_nxt),
    .err   (err_nxt)
  );
`else
  imm_scatter u_scatter (
    .req   (req),
    .instr (instr_nxt)
  );
`endif

  // Output register and address counter. The address always names the held
  // word: it steps on each drain, so a same-cycle reload gets the next slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_instr <= 32'h0;
      bus.out_addr  <= BASE_ADDR;
    end else begin
      if (drain) begin
        bus.out_addr <= bus.out_addr + ADDR_WIDTH'(4);
      end
      if (take) begin
        bus.out_valid <= 1'b1;
        bus.out_instr <= instr_nxt;
      end else if (drain) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef IMM_PACK_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_err   <= 1'b0;
      bus.err_count <= 16'h0;
    end else begin
      if (take) begin
        bus.out_err <= err_nxt;
      end
      // Counted when the consumer takes the word, saturating at all-ones.
      if (drain && bus.out_err && (bus.err_count != 16'hFFFF)) begin
        bus.err_count <= bus.err_count + 16'd1;
      end
    end
  end
`else
  assign bus.out_err   = 1'b0;
  assign bus.err_count = 16'h0;
`endif

endmodule
